// File: rtl/mul_sequencer.sv
// mul_sequencer: sequential WIDTH x WIDTH multiplier, one iteration per cycle, full 2*WIDTH-bit product
// Ports:
//   Clock        - single clock, rising edge
//   Reset        - asynchronous active-high reset
//   iStart       - begin a multiply with iA/iB (honoured only in IDLE)
//   iAbort       - cancel a multiply in progress (CALC only, beats iStart)
//   iA, iB       - multiplicand, multiplier
//   oBusy        - high while in CALC
//   oDone        - one-cycle pulse when the result is valid
//   oWriteEnable - same as oDone, strobes both result words
//   oResultLo/Hi - low/high product words, updated only on entry to DONE
// Build option: MUL_SEQ_SIGNED_EN selects two's-complement radix-2 Booth; undefined selects unsigned shift-add.
module mul_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic             iAbort,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResultLo,
  output logic [WIDTH-1:0] oResultHi,
  output logic             oWriteEnable
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_mcand, r_hi, r_lo, r_res_lo, r_res_hi;
  logic [WIDTH-1:0] w_hi_nx, w_lo_nx;
  logic [WIDTH:0]   w_sum;
  logic [CW-1:0]    r_cnt;
  logic             w_last, w_step, w_load;
  assign w_last = r_cnt == CW'(WIDTH - 1);
  assign w_load = r_state == IDLE && iStart;
  assign w_step = r_state == CALC && !iAbort;
`ifdef MUL_SEQ_SIGNED_EN
  logic r_guard;
  // Sum is kept one bit wider than hi so that adding/subtracting the most negative
  // multiplicand cannot overflow; dropping its LSB is the arithmetic right shift.
  always_comb begin
    w_sum = (r_lo[0] == r_guard) ? {r_hi[WIDTH-1], r_hi}
          : r_lo[0] ? {r_hi[WIDTH-1], r_hi} - {r_mcand[WIDTH-1], r_mcand}
          : {r_hi[WIDTH-1], r_hi} + {r_mcand[WIDTH-1], r_mcand};
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_guard <= 1'b0;
    else if (w_load) r_guard <= 1'b0;
    else if (w_step) r_guard <= r_lo[0];
  end
`else
  // Carry-out lands in w_sum[WIDTH] and is shifted back into hi.
  always_comb w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
`endif
  assign w_hi_nx = w_sum[WIDTH:1];
  assign w_lo_nx = {w_sum[0], r_lo[WIDTH-1:1]};
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (iStart ? CALC : IDLE)
           : (r_state == CALC) ? (iAbort ? IDLE : w_last ? DONE : CALC)
           : IDLE;
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_mcand  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
    end else if (w_load) begin
      r_mcand <= iA;
      r_hi    <= '0;
      r_lo    <= iB;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_hi  <= w_hi_nx;
      r_lo  <= w_lo_nx;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_res_hi <= w_hi_nx;
        r_res_lo <= w_lo_nx;
      end
    end
  end
  assign oBusy        = r_state == CALC;
  assign oDone        = r_state == DONE;
  assign oWriteEnable = r_state == DONE;
  assign oResultLo    = r_res_lo;
  assign oResultHi    = r_res_hi;
endmodule
